// File: rtl/hazard_pkg.sv
// Shared opcode-group encoding and operand-usage decode for the hazard unit.
package hazard_pkg;

  localparam logic [2:0] OPG_LOAD   = 3'b000;
  localparam logic [2:0] OPG_IMM    = 3'b001;
  localparam logic [2:0] OPG_STORE  = 3'b010;
  localparam logic [2:0] OPG_RTYPE  = 3'b011;
  localparam logic [2:0] OPG_BRANCH = 3'b110;

  function automatic logic uses_rs1(input logic [2:0] grp);
    return (grp == OPG_LOAD) || (grp == OPG_IMM) || (grp == OPG_STORE) ||
           (grp == OPG_RTYPE) || (grp == OPG_BRANCH);
  endfunction

  function automatic logic uses_rs2(input logic [2:0] grp);
    return (grp == OPG_STORE) || (grp == OPG_RTYPE) || (grp == OPG_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Load-use hazard detection and branch-flush steering for the 5-stage core,
// with saturating stall/flush event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       ifid_opcode,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic [4:0]       ifid_rd,
  input  logic             mem_branch_taken,
  output logic             hazard_mux,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic       r_idex_load_q;
  logic [4:0] r_idex_rd_q;

  logic [2:0] w_group;
  logic       w_is_load;
  logic       w_load_use;
  logic       w_stall;
  logic       w_flush;
  logic       w_unused_opc;

  assign w_group      = ifid_opcode[6:4];
  assign w_unused_opc = ^ifid_opcode[3:0];
  assign w_is_load    = (w_group == OPG_LOAD);

  assign w_load_use = r_idex_load_q && (r_idex_rd_q != 5'd0) &&
                      ((uses_rs1(w_group) && (r_idex_rd_q == ifid_rs1)) ||
                       (uses_rs2(w_group) && (r_idex_rd_q == ifid_rs2)));

  // Reset masks both events so the steering outputs fall back to normal flow.
  assign w_flush = mem_branch_taken && !reset;
  assign w_stall = w_load_use && !mem_branch_taken && !reset;

  assign hazard_mux  = w_stall;
  assign pc_write    = !w_stall;
  assign ifid_write  = !w_stall;
  assign ifid_flush  = w_flush;
  assign idex_flush  = w_flush;
  assign exmem_flush = w_flush;

  // Shadow of the ID/EX slot; a bubble or flushed slot is never a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idex_load_q <= 1'b0;
      r_idex_rd_q   <= 5'd0;
    end else begin
      r_idex_load_q <= w_is_load && !w_stall && !w_flush;
      r_idex_rd_q   <= ifid_rd;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios then random instruction streams,
// checked against an instruction-level reference model.
module tb_hazard_unit;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic             clk;
  logic             reset;
  logic [6:0]       ifid_opcode;
  logic [4:0]       ifid_rs1, ifid_rs2, ifid_rd;
  logic             mem_branch_taken;
  logic             hazard_mux, pc_write, ifid_write;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what instruction went into ID/EX on the last edge.
  bit       m_prev_load;
  int       m_prev_rd;
  int       m_stalls;
  int       m_flushes;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .ifid_opcode      (ifid_opcode),
    .ifid_rs1         (ifid_rs1),
    .ifid_rs2         (ifid_rs2),
    .ifid_rd          (ifid_rd),
    .mem_branch_taken (mem_branch_taken),
    .hazard_mux       (hazard_mux),
    .pc_write         (pc_write),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one IF/ID instruction for one cycle, compare, then advance the model.
  task automatic step(input logic [6:0] op, input int rs1, input int rs2, input int rd,
                      input bit br, input bit rst);
    int  grp;
    bit  is_load, u1, u2, dep, flush, stall;
    logic [5:0] exp_o, obs_o;
    @(negedge clk);
    ifid_opcode      = op;
    ifid_rs1         = 5'(rs1);
    ifid_rs2         = 5'(rs2);
    ifid_rd          = 5'(rd);
    mem_branch_taken = br;
    reset            = rst;
    #1;
    grp     = int'(op[6:4]);
    is_load = (grp == 0);
    u1      = (grp == 0) || (grp == 1) || (grp == 2) || (grp == 3) || (grp == 6);
    u2      = (grp == 2) || (grp == 3) || (grp == 6);
    dep     = m_prev_load && (m_prev_rd != 0) &&
              ((u1 && m_prev_rd == rs1) || (u2 && m_prev_rd == rs2));
    flush   = br && !rst;
    stall   = dep && !br && !rst;
    exp_o   = {stall, !stall, !stall, flush, flush, flush};
    obs_o   = {hazard_mux, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush};
    check("steer", 32'(obs_o), 32'(exp_o));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
    if (rst) begin
      m_prev_load = 0;
      m_prev_rd   = 0;
      m_stalls    = 0;
      m_flushes   = 0;
    end else begin
      m_prev_load = is_load && !stall && !flush;
      m_prev_rd   = rd;
      if (stall && m_stalls < CMAX)  m_stalls++;
      if (flush && m_flushes < CMAX) m_flushes++;
    end
  endtask

  initial begin
    logic [6:0] rop;
    reset = 1'b1; ifid_opcode = OP_ADDI; ifid_rs1 = '0; ifid_rs2 = '0; ifid_rd = '0;
    mem_branch_taken = 1'b0;
    m_prev_load = 0; m_prev_rd = 0; m_stalls = 0; m_flushes = 0;

    step(OP_ADDI, 0, 0, 0, 0, 1);
    step(OP_LW,   0, 0, 5, 0, 1);                 // load under reset is not shadowed
    step(OP_ADD,  5, 0, 1, 0, 0);

    // Load-use on rs1: one stall, held instruction then proceeds
    step(OP_LW,   1, 0, 5, 0, 0);
    step(OP_ADD,  5, 2, 6, 0, 0);
    check("stall_rs1", 32'(hazard_mux), 32'd1);
    step(OP_ADD,  5, 2, 6, 0, 0);
    check("stall_released", 32'(pc_write), 32'd1);
    check("stall_cnt_one", 32'(stall_cnt), 32'd1);

    step(OP_LW,   1, 0, 7, 0, 0);                 // store reading rs2
    step(OP_SW,   2, 7, 0, 0, 0);
    step(OP_SW,   2, 7, 0, 0, 0);
    step(OP_LW,   1, 0, 7, 0, 0);                 // addi ignores rs2 field
    step(OP_ADDI, 2, 7, 8, 0, 0);
    step(OP_LW,   1, 0, 0, 0, 0);                 // rd==x0
    step(OP_ADD,  0, 0, 9, 0, 0);
    step(OP_LW,   3, 3, 3, 0, 0);                 // rd==rs1==rs2: single stall
    step(OP_ADD,  3, 3, 4, 0, 0);
    step(OP_ADD,  3, 3, 4, 0, 0);
    step(OP_LW,   1, 0, 2, 0, 0);                 // load -> load -> use
    step(OP_LW,   2, 0, 3, 0, 0);
    step(OP_LW,   2, 0, 3, 0, 0);
    step(OP_ADD,  3, 0, 4, 0, 0);
    step(OP_ADD,  3, 0, 4, 0, 0);

    // Flush beats a simultaneous load-use
    step(OP_ADDI, 0, 0, 0, 0, 1);
    step(OP_LW,   1, 0, 5, 0, 0);
    step(OP_ADD,  5, 0, 6, 1, 0);
    check("flush_prio_mux", 32'(hazard_mux), 32'd0);
    step(OP_ADD,  5, 0, 6, 0, 0);
    check("flush_cnt_one", 32'(flush_cnt), 32'd1);
    check("stall_cnt_zero", 32'(stall_cnt), 32'd0);

    // Saturation after five stalls
    step(OP_ADDI, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(OP_LW,  1, 0, 5, 0, 0);
      step(OP_ADD, 5, 0, 0, 0, 0);
      step(OP_ADD, 5, 0, 0, 0, 0);
    end
    check("stall_sat", 32'(stall_cnt), 32'(CMAX));

    // Reset arriving on a stall cycle
    step(OP_LW,   1, 0, 5, 0, 0);
    step(OP_ADD,  5, 0, 6, 0, 1);
    check("reset_mid_stall", 32'(pc_write), 32'd1);
    step(OP_ADD,  5, 0, 6, 0, 0);
    check("reset_no_stall", 32'(hazard_mux), 32'd0);
    check("reset_cnt_clear", 32'(stall_cnt), 32'd0);

    // Random streams over a small register file to provoke dependences
    for (int i = 0; i < 600; i++) begin
      rop = 7'($urandom);
      if ($urandom_range(0, 2) == 0) rop[6:4] = 3'b000;
      step(rop, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
